// File: rtl/heichips25_cryo_counter.sv
// Multi-channel gated rising-edge counter with shadow result registers and byte-wise readout.
// Channel inputs and the start bit are synchronised; select inputs are sampled raw.
module heichips25_cryo_counter #(
  parameter int NUM_CH      = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int GATE_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       iout
);

  localparam int NIN = NUM_CH + 1;
  localparam int SI  = NUM_CH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NIN-1:0]          w_raw;
  logic [NIN-1:0]          r_sync [SYNC_STAGES];
  logic [NIN-1:0]          r_sync_d;
  logic [NIN-1:0]          w_pulse;
  logic [NUM_CH-1:0]       w_edge;
  logic                    w_start;
  logic                    w_last;
  logic [1:0]              r_exp;
  logic [GATE_WIDTH-1:0]   r_gate;
  logic [CNT_WIDTH-1:0]    r_cnt     [NUM_CH];
  logic [CNT_WIDTH-1:0]    w_cnt_nxt [NUM_CH];
  logic [CNT_WIDTH-1:0]    r_res     [NUM_CH];
  logic [NUM_CH-1:0]       r_ovf;
  logic [NUM_CH-1:0]       w_ovf_nxt;
  logic [NUM_CH-1:0]       r_res_ovf;
  logic [2:0]              w_c;
  logic [1:0]              w_b;
  logic [23:0]             w_sel_cnt;
  logic                    w_sel_ovf;
  logic                    w_sel_valid;
  logic [7:0]              w_byte;
  logic [7:0]              r_uo;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_any_ovf;
  logic                    w_unused;

  // Last gate-counter value for a window of 256 << (2*E) cycles.
  function automatic logic [GATE_WIDTH-1:0] gate_last(input logic [1:0] e);
    gate_last = (GATE_WIDTH'(9'd256) << {e, 1'b0}) - GATE_WIDTH'(1'b1);
  endfunction

  // Gather the asynchronous inputs: channels first, start bit on top.
  always_comb begin
    w_raw    = '0;
    w_raw[0] = iout;
    for (int n = 1; n < NUM_CH; n++) w_raw[n] = uio_in[n-1];
    w_raw[SI] = ui_in[0];
  end

  // Synchroniser chain plus delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_sync_d <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_pulse = r_sync[SYNC_STAGES-1] & ~r_sync_d;
  assign w_edge  = w_pulse[NUM_CH-1:0];
  assign w_start = w_pulse[SI];
  assign w_last  = (r_state == ST_COUNT) && (r_gate == '0);

  // Next-state logic; starts seen while armed or counting are dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start) w_state_nxt = ST_ARM;
        else         w_state_nxt = r_state;
      end
      ST_ARM:   w_state_nxt = ST_COUNT;
      ST_COUNT: begin
        if (r_gate == '0) w_state_nxt = ST_DONE;
        else              w_state_nxt = ST_COUNT;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Saturating increment per channel; an edge at all-ones flags overflow.
  always_comb begin
    w_ovf_nxt = r_ovf;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_cnt_nxt[ch] = r_cnt[ch];
      if (w_edge[ch] && (r_cnt[ch] == {CNT_WIDTH{1'b1}})) begin
        w_cnt_nxt[ch] = r_cnt[ch];
        w_ovf_nxt[ch] = 1'b1;
      end else if (w_edge[ch]) begin
        w_cnt_nxt[ch] = r_cnt[ch] + CNT_WIDTH'(1'b1);
        w_ovf_nxt[ch] = r_ovf[ch];
      end else begin
        w_cnt_nxt[ch] = r_cnt[ch];
        w_ovf_nxt[ch] = r_ovf[ch];
      end
    end
  end

  // Measurement state, live counters and result shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_exp     <= 2'd0;
      r_gate    <= '0;
      r_ovf     <= '0;
      r_res_ovf <= '0;
      r_any_ovf <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_cnt[ch] <= '0;
        r_res[ch] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) r_exp <= ui_in[7:6];
        end
        ST_ARM: begin
          r_gate <= gate_last(r_exp);
          r_ovf  <= '0;
          for (int ch = 0; ch < NUM_CH; ch++) r_cnt[ch] <= '0;
        end
        ST_COUNT: begin
          r_gate <= r_gate - GATE_WIDTH'(1'b1);
          r_ovf  <= w_ovf_nxt;
          for (int ch = 0; ch < NUM_CH; ch++) r_cnt[ch] <= w_cnt_nxt[ch];
          if (w_last) begin
            r_res_ovf <= w_ovf_nxt;
            r_any_ovf <= |w_ovf_nxt;
            for (int ch = 0; ch < NUM_CH; ch++) r_res[ch] <= w_cnt_nxt[ch];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_c         = ui_in[3:1];
  assign w_b         = ui_in[5:4];
  assign w_sel_valid = ({1'b0, w_c} < 4'(NUM_CH));

  // Readout mux: channel select by masking, zero-filled above the counter width.
  always_comb begin
    w_sel_cnt = 24'h000000;
    w_sel_ovf = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_sel_cnt = w_sel_cnt | ({24{w_c == 3'(ch)}} & 24'(r_res[ch]));
      w_sel_ovf = w_sel_ovf | ((w_c == 3'(ch)) & r_res_ovf[ch]);
    end
    case (w_b)
      2'd0:    w_byte = w_sel_cnt[7:0];
      2'd1:    w_byte = w_sel_cnt[15:8];
      2'd2:    w_byte = w_sel_cnt[23:16];
      2'd3:    w_byte = w_sel_valid ? {w_sel_ovf, 5'b00000, r_state} : 8'h00;
      default: w_byte = 8'h00;
    endcase
  end

  // Output registers; busy/done follow the next state so they align with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uo   <= 8'h00;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_uo   <= w_byte;
      r_busy <= (w_state_nxt == ST_ARM) || (w_state_nxt == ST_COUNT);
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  assign uo_out   = r_uo;
  assign uio_out  = {r_busy, r_done, r_any_ovf, r_sync[SYNC_STAGES-1][0], 4'h0};
  assign uio_oe   = 8'hF0;
  assign w_unused = &{1'b0, ena, uio_in};

endmodule

// File: tb/tb_heichips25_cryo_counter.sv
// Self-checking bench: a 3-channel/16-bit instance and a 1-channel/8-bit saturating instance share stimulus.
// Expected counts come from table constants or from a model that counts rises in the recorded input history.
module tb_heichips25_cryo_counter;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic       iout = 1'b0;
  logic [7:0] uo_m, uio_out_m, uio_oe_m;
  logic [7:0] uo_s, uio_out_s, uio_oe_s;

  heichips25_cryo_counter #(.NUM_CH(3), .CNT_WIDTH(16), .GATE_WIDTH(16), .SYNC_STAGES(S)) dut_m (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_m),
    .uio_in(uio_in), .uio_out(uio_out_m), .uio_oe(uio_oe_m), .iout(iout));

  heichips25_cryo_counter #(.NUM_CH(1), .CNT_WIDTH(8), .GATE_WIDTH(15), .SYNC_STAGES(S)) dut_s (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_s),
    .uio_in(uio_in), .uio_out(uio_out_s), .uio_oe(uio_oe_s), .iout(iout));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [2:0] h_ch [65536];
  int mode [3] = '{2, 2, 2};
  int per  [3] = '{2, 2, 2};
  int prev_m_b0 = 0, prev_s_b0 = 0, prev_s_ovf = 0;

  // History of channel values as seen at each rising clock edge.
  always @(posedge clk) begin
    if (cyc < 65536) h_ch[cyc] <= {uio_in[1:0], iout};
    cyc <= cyc + 1;
  end

  // Channel stimulus: 0 low, 1 periodic, 2 random bits, 3 sparse random.
  always @(negedge clk) begin : drv
    logic [2:0] v;
    for (int c = 0; c < 3; c++) begin
      case (mode[c])
        0:       v[c] = 1'b0;
        1:       v[c] = ((cyc % per[c]) < (per[c] / 2));
        2:       v[c] = 1'($urandom_range(0, 1));
        default: v[c] = ($urandom_range(0, 7) == 0);
      endcase
    end
    iout   <= v[0];
    uio_in <= {6'($urandom_range(0, 63)), v[2:1]};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int satv(input int v, input int w);
    return (v > ((1 << w) - 1)) ? ((1 << w) - 1) : v;
  endfunction

  // Rising edges sampled inside the gate window that follows a start sampled at edge t0.
  function automatic int model_cnt(input int ch, input int t0, input int g);
    int n = 0;
    for (int k = t0 + 2; k <= t0 + 1 + g; k++)
      if (k < 65536 && h_ch[k][ch] && !h_ch[k-1][ch]) n++;
    return n;
  endfunction

  // Read every channel/byte on both instances and the status bits.
  task automatic verify(input int c0, input int c1, input int c2, input logic [1:0] st, input string tag);
    int cnt [3];
    int v, ovf, em, es, any_m;
    cnt = '{c0, c1, c2};
    any_m = 0;
    for (int c = 0; c < 8; c++) begin
      for (int b = 0; b < 4; b++) begin
        ui_in[3:1] = 3'(c);
        ui_in[5:4] = 2'(b);
        @(posedge clk); #1;
        em = 0;
        es = 0;
        if (c < 3) begin
          v = satv(cnt[c], 16);
          ovf = (cnt[c] > 65535) ? 1 : 0;
          any_m |= ovf;
          em = (b < 3) ? ((v >> (8 * b)) & 255) : ((ovf << 7) | int'(st));
        end
        if (c == 0) begin
          v = satv(cnt[0], 8);
          ovf = (cnt[0] > 255) ? 1 : 0;
          es = (b < 3) ? ((v >> (8 * b)) & 255) : ((ovf << 7) | int'(st));
        end
        check($sformatf("%s_m_c%0d_b%0d", tag, c, b), uo_m, em);
        check($sformatf("%s_s_c%0d_b%0d", tag, c, b), uo_s, es);
      end
    end
    v = ((st == 2'd1 || st == 2'd2) ? 128 : 0) | ((st == 2'd3) ? 64 : 0);
    check($sformatf("%s_uio_m", tag), uio_out_m & 8'hEF, v | (any_m << 5));
    check($sformatf("%s_uio_s", tag), uio_out_s & 8'hEF, v | ((cnt[0] > 255 ? 1 : 0) << 5));
    prev_m_b0  = c0 & 255;
    prev_s_b0  = satv(c0, 8) & 255;
    prev_s_ovf = (c0 > 255) ? 1 : 0;
  endtask

  // One measurement: start, busy timing, old results readable, retrigger ignored, optional abort.
  task automatic run(input logic [1:0] e, input int abort_at, output int t0, output bit aborted);
    int g, n;
    bit seen;
    g = 256 << (2 * e);
    aborted = 1'b0;
    ui_in[7:6] = e;
    ui_in[0] = 1'b1;
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (uio_out_m[7]) begin
        seen = 1'b1;
        break;
      end
    end
    check("start_latency", seen ? (cyc - 1 - t0) : -1, S);
    ui_in[0] = 1'b0;
    if (!seen) return;
    n = 1;
    for (int j = 0; j < g + 20; j++) begin
      if (n == 20) ui_in[5:1] = 5'b00000;
      if (n == 21) ui_in[5:1] = 5'b11000;
      if (n == 40) begin ui_in[7:6] = ~e; ui_in[0] = 1'b1; end
      if (n == 45) begin ui_in[7:6] = e;  ui_in[0] = 1'b0; end
      if (abort_at > 0 && n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_uo_m", uo_m, 0);
        check("abort_uio_m", uio_out_m, 0);
        check("abort_uo_s", uo_s, 0);
        check("abort_uio_s", uio_out_s, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        aborted = 1'b1;
        return;
      end
      @(posedge clk); #1;
      if (n == 20) begin
        check("prev_b0_m", uo_m, prev_m_b0);
        check("prev_b0_s", uo_s, prev_s_b0);
      end
      if (n == 21) begin
        check("busy_b3_m", uo_m, 8'h02);
        check("busy_b3_s", uo_s, (prev_s_ovf << 7) | 2);
      end
      if (!uio_out_m[7]) break;
      n++;
    end
    check("busy_len", n, g + 1);
    check("done_flag", uio_out_m[6], 1);
  endtask

  typedef struct {
    logic [1:0] e;
    int p0, p1, p2;
    int c0, c1, c2;
  } row_t;

  row_t tbl [4];

  initial begin : main
    int t0;
    bit ab;
    logic [1:0] e;
    tbl[0] = '{2'd0, 2, 0, 0, 128, 0, 0};
    tbl[1] = '{2'd1, 2, 4, 8, 512, 256, 128};
    tbl[2] = '{2'd2, 16, 2, 0, 256, 2048, 0};
    tbl[3] = '{2'd3, 0, 8, 2, 0, 2048, 8192};

    // Reset with random inputs.
    for (int i = 0; i < 6; i++) begin
      ui_in = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    check("rst_uo_m", uo_m, 0);
    check("rst_uio_m", uio_out_m, 0);
    check("rst_oe_m", uio_oe_m, 8'hF0);
    check("rst_uo_s", uo_s, 0);
    check("rst_uio_s", uio_out_s, 0);
    check("rst_oe_s", uio_oe_s, 8'hF0);
    ui_in = 8'h30;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_b3_m", uo_m, 0);
    check("post_rst_b3_s", uo_s, 0);

    // Deterministic periodic runs; later rows start from DONE with a new E.
    for (int r = 0; r < 4; r++) begin
      mode = '{(tbl[r].p0 != 0) ? 1 : 0, (tbl[r].p1 != 0) ? 1 : 0, (tbl[r].p2 != 0) ? 1 : 0};
      per  = '{(tbl[r].p0 != 0) ? tbl[r].p0 : 2, (tbl[r].p1 != 0) ? tbl[r].p1 : 2,
               (tbl[r].p2 != 0) ? tbl[r].p2 : 2};
      run(tbl[r].e, 0, t0, ab);
      verify(tbl[r].c0, tbl[r].c1, tbl[r].c2, 2'd3, $sformatf("row%0d", r));
    end

    // Random channel activity against the history model.
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 3; c++) begin
        mode[c] = $urandom_range(1, 3);
        per[c]  = $urandom_range(2, 9);
      end
      e = 2'($urandom_range(0, 1));
      run(e, 0, t0, ab);
      verify(model_cnt(0, t0, 256 << (2 * e)), model_cnt(1, t0, 256 << (2 * e)),
             model_cnt(2, t0, 256 << (2 * e)), 2'd3, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of a gate window, then a clean run.
    mode = '{1, 1, 1};
    per  = '{2, 4, 8};
    run(2'd1, 100, t0, ab);
    check("abort_taken", ab, 1);
    verify(0, 0, 0, 2'd0, "abort");
    run(2'd1, 0, t0, ab);
    verify(512, 256, 128, 2'd3, "rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
